// File: rtl/io_pkg.sv
// Shared I/O-space constants for the single-cycle computer's memory-mapped ports.
package io_pkg;

  // Address bits that select an I/O register.
  localparam int IO_SEL_MSB = 7;
  localparam int IO_SEL_LSB = 2;
  localparam int IO_SEL_W   = IO_SEL_MSB - IO_SEL_LSB + 1;

  // Default word indices of the input bank.
  localparam logic [IO_SEL_W-1:0] IO_IN_BASE_IDX   = 6'b110000;
  localparam logic [IO_SEL_W-1:0] IO_IN_STATUS_IDX = 6'b111111;

  // Width of a debounce counter that must count 0..cycles-1; at least 1 bit.
  function automatic int io_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/io_input_chan.sv
// One input channel: 2-FF synchroniser, optional debounce filter, accepted
// value register and a sticky change flag (set beats clear).
module io_input_chan
  import io_pkg::*;
#(
  parameter int W               = 32,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic         io_clk,
  input  logic         resetn,
  input  logic [W-1:0] in_bits,
  input  logic         flag_clr,
  output logic [W-1:0] val,
  output logic         flag
);

  logic [W-1:0] s1_reg;
  logic [W-1:0] s2_reg;
  logic [W-1:0] val_reg;
  logic         flag_reg;
  logic         accept;
  logic [W-1:0] accept_val;

  // Two-stage synchroniser for the asynchronous pins.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= in_bits;
      s2_reg <= s1_reg;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nofilt
      // Without a filter every synchronised change is accepted immediately.
      assign accept     = (s2_reg != val_reg);
      assign accept_val = s2_reg;
    end else begin : g_filt
      localparam int CNT_W = io_cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [W-1:0]     cand_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Track the candidate value and count how long it has been stable.
      always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
          cand_reg <= '0;
          cnt_reg  <= '0;
        end else if (s2_reg != cand_reg) begin
          cand_reg <= s2_reg;
          cnt_reg  <= '0;
        end else if (cand_reg != val_reg) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      // Candidate differs from val and has survived the full stable window.
      assign accept     = (s2_reg == cand_reg) && (cand_reg != val_reg) && (cnt_reg == CNT_LAST);
      assign accept_val = cand_reg;
    end
  endgenerate

  // Accepted value and sticky change flag; a new change wins over a clear.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      val_reg  <= '0;
      flag_reg <= 1'b0;
    end else begin
      if (accept) begin
        val_reg <= accept_val;
      end
      if (accept) begin
        flag_reg <= 1'b1;
      end else if (flag_clr) begin
        flag_reg <= 1'b0;
      end
    end
  end

  assign val  = val_reg;
  assign flag = flag_reg;

endmodule

// File: rtl/io_input_bank.sv
// Memory-mapped bank of N_CH input channels with a read-to-clear change
// status word and a level interrupt.
module io_input_bank
  import io_pkg::*;
#(
  parameter int                  N_CH            = 2,
  parameter int                  W               = 32,
  parameter logic [IO_SEL_W-1:0] BASE_IDX        = IO_IN_BASE_IDX,
  parameter logic [IO_SEL_W-1:0] STATUS_IDX      = IO_IN_STATUS_IDX,
  parameter int                  DEBOUNCE_CYCLES = 0
) (
  input  logic              io_clk,
  input  logic              resetn,
  input  logic [31:0]       addr,
  input  logic              rd_en,
  input  logic [N_CH*W-1:0] in_port,
  output logic [31:0]       io_read_data,
  output logic              irq
);

  logic [IO_SEL_W-1:0] sel;
  logic [N_CH-1:0]     flag;
  logic [N_CH-1:0]     ch_hit;
  logic [31:0]         ch_word [N_CH];
  logic                status_hit;
  logic                flag_clr;
  logic                addr_unused;

  assign sel         = addr[IO_SEL_MSB:IO_SEL_LSB];
  assign addr_unused = ^{addr[31:IO_SEL_MSB+1], addr[IO_SEL_LSB-1:0]};

  // Status word is cleared only by an actual read strobe to its index.
  assign status_hit = (sel == STATUS_IDX);
  assign flag_clr   = rd_en & status_hit;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [IO_SEL_W-1:0] CH_IDX = IO_SEL_W'(BASE_IDX + gi);

    logic [W-1:0] val;

    io_input_chan #(
      .W               (W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .io_clk   (io_clk),
      .resetn   (resetn),
      .in_bits  (in_port[gi*W +: W]),
      .flag_clr (flag_clr),
      .val      (val),
      .flag     (flag[gi])
    );

    assign ch_hit[gi]  = (sel == CH_IDX);
    assign ch_word[gi] = 32'(val);
  end

  // Read mux: a channel value, the status word, or zero for unmapped indices.
  always_comb begin
    io_read_data = 32'h0;
    if (status_hit) begin
      io_read_data = 32'(flag);
    end
    for (int i = 0; i < N_CH; i++) begin
      if (ch_hit[i]) begin
        io_read_data = ch_word[i];
      end
    end
  end

  // Interrupt is a plain OR of registered flags, so it never glitches on pins.
  assign irq = |flag;

endmodule

// File: tb/tb_io_input_bank.sv
module tb_io_input_bank;

  logic io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  logic        resetn;
  logic [31:0] addr0, addr1, addr2;
  logic        rd_en0, rd_en1, rd_en2;
  logic [63:0] in0, in1;
  logic [23:0] in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  io_input_bank #(
    .N_CH(2), .W(32), .BASE_IDX(6'b110000), .STATUS_IDX(6'b111111), .DEBOUNCE_CYCLES(0)
  ) u_dut0 (
    .io_clk(io_clk), .resetn(resetn), .addr(addr0), .rd_en(rd_en0),
    .in_port(in0), .io_read_data(rd0), .irq(irq0)
  );

  io_input_bank #(
    .N_CH(2), .W(32), .BASE_IDX(6'b110000), .STATUS_IDX(6'b111111), .DEBOUNCE_CYCLES(4)
  ) u_dut1 (
    .io_clk(io_clk), .resetn(resetn), .addr(addr1), .rd_en(rd_en1),
    .in_port(in1), .io_read_data(rd1), .irq(irq1)
  );

  io_input_bank #(
    .N_CH(3), .W(8), .BASE_IDX(6'b110000), .STATUS_IDX(6'b111111), .DEBOUNCE_CYCLES(0)
  ) u_dut2 (
    .io_clk(io_clk), .resetn(resetn), .addr(addr2), .rd_en(rd_en2),
    .in_port(in2), .io_read_data(rd2), .irq(irq2)
  );

  int checks = 0;
  int errors = 0;

  int          q_dut  [$];
  logic [31:0] q_data [$];
  logic        q_irq  [$];
  string       q_name [$];

  int          m_dut;
  logic [31:0] m_exp_d, m_got_d;
  logic        m_exp_i, m_got_i;
  string       m_name;

  task automatic step(input int n);
    repeat (n) @(posedge io_clk);
    #1;
  endtask

  task automatic sb_push(input int dut, input string name, input logic [31:0] data, input logic irq_exp);
    q_dut.push_back(dut);
    q_data.push_back(data);
    q_irq.push_back(irq_exp);
    q_name.push_back(name);
  endtask

  always @(negedge io_clk) begin
    while (q_dut.size() > 0) begin
      m_dut   = q_dut.pop_front();
      m_exp_d = q_data.pop_front();
      m_exp_i = q_irq.pop_front();
      m_name  = q_name.pop_front();
      case (m_dut)
        0:       begin m_got_d = rd0; m_got_i = irq0; end
        1:       begin m_got_d = rd1; m_got_i = irq1; end
        default: begin m_got_d = rd2; m_got_i = irq2; end
      endcase
      checks++;
      if (m_got_d !== m_exp_d || m_got_i !== m_exp_i) begin
        errors++;
        $display("FAIL %s dut%0d: got data=%h irq=%b, expected data=%h irq=%b",
                 m_name, m_dut, m_got_d, m_got_i, m_exp_d, m_exp_i);
      end else begin
        $display("ok   %s dut%0d: data=%h irq=%b", m_name, m_dut, m_got_d, m_got_i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    in0 = '1; in1 = '1; in2 = '1;
    addr0 = 32'h0; addr1 = 32'h0; addr2 = 32'h0;
    rd_en0 = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0;
    step(1);

    checks++;
    if (rd0 !== 32'h0 || irq0 !== 1'b0) begin
        errors++;
        $display("FAIL rst_direct dut0: got data=%h irq=%b, expected data=00000000 irq=0", rd0, irq0);
    end else begin
        $display("ok   rst_direct dut0: data=%h irq=%b", rd0, irq0);
    end

    for (int idx = 0; idx < 64; idx++) begin
      addr0 = {24'h0, idx[5:0], 2'b00};
      addr1 = addr0;
      addr2 = addr0;
      sb_push(0, "rst_idx", 32'h0, 1'b0);
      sb_push(1, "rst_idx", 32'h0, 1'b0);
      sb_push(2, "rst_idx", 32'h0, 1'b0);
      step(1);
    end
    in1 = '0; in2 = '0;
    addr0 = 32'hC0; addr1 = 32'hC0; addr2 = 32'hC0;
    resetn = 1'b1;
    sb_push(0, "rel_pre", 32'h0, 1'b0);
    step(1);
    sb_push(0, "rel_e0", 32'h0, 1'b0);
    step(1);
    sb_push(0, "rel_e1", 32'h0, 1'b0);
    step(1);
    sb_push(0, "rel_e2", 32'hFFFF_FFFF, 1'b1);

    in0[63:32] = 32'h0;
    step(3);
    addr0 = 32'hFC; rd_en0 = 1'b1;
    sb_push(0, "prep_st", 32'h3, 1'b1);
    step(1);
    rd_en0 = 1'b0;
    sb_push(0, "prep_clr", 32'h0, 1'b0);

    addr0 = 32'hC4;
    in0[63:32] = 32'h0000_00A5;
    sb_push(0, "lat_pre", 32'h0, 1'b0);
    step(1);
    sb_push(0, "lat_e0", 32'h0, 1'b0);
    step(1);
    sb_push(0, "lat_e1", 32'h0, 1'b0);
    step(1);
    sb_push(0, "lat_e2", 32'h0000_00A5, 1'b1);
    step(1);
    addr0 = 32'hFC;
    sb_push(0, "lat_st", 32'h2, 1'b1);

    in0[31:0] = 32'h0;
    step(3);
    rd_en0 = 1'b1;
    sb_push(0, "r2c_pre", 32'h3, 1'b1);
    step(1);
    rd_en0 = 1'b0;
    sb_push(0, "r2c_post", 32'h0, 1'b0);
    step(1);
    addr0 = 32'hC0;
    sb_push(0, "r2c_ch0", 32'h0, 1'b0);

    in2 = 24'h3C_5A_81;
    step(3);
    addr2 = 32'hC8; sb_push(2, "dec_c8", 32'h0000_003C, 1'b1); step(1);
    addr2 = 32'hC0; sb_push(2, "dec_c0", 32'h0000_0081, 1'b1); step(1);
    addr2 = 32'hC4; sb_push(2, "dec_c4", 32'h0000_005A, 1'b1); step(1);
    addr2 = 32'hCC; sb_push(2, "dec_cc", 32'h0, 1'b1); step(1);
    addr2 = 32'hD0; sb_push(2, "dec_d0", 32'h0, 1'b1); step(1);
    addr2 = 32'h00; sb_push(2, "dec_00", 32'h0, 1'b1); step(1);
    addr2 = 32'hC8; rd_en2 = 1'b1;
    sb_push(2, "dec_chrd", 32'h0000_003C, 1'b1);
    step(1);
    rd_en2 = 1'b0; addr2 = 32'hFC;
    sb_push(2, "dec_st", 32'h7, 1'b1);
    step(1);
    rd_en2 = 1'b1;
    sb_push(2, "dec_st_rd", 32'h7, 1'b1);
    step(1);
    rd_en2 = 1'b0;
    sb_push(2, "dec_st_clr", 32'h0, 1'b0);

    addr1 = 32'hC0;
    in1[0] = 1'b1;
    step(3);
    in1[0] = 1'b0;
    step(8);
    sb_push(1, "glitch_val", 32'h0, 1'b0);
    step(1);
    addr1 = 32'hFC;
    sb_push(1, "glitch_st", 32'h0, 1'b0);
    step(1);

    addr1 = 32'hC0;
    in1[0] = 1'b1;
    step(6);
    sb_push(1, "deb_e5", 32'h0, 1'b0);
    step(1);
    sb_push(1, "deb_e6", 32'h1, 1'b1);
    step(1);
    addr1 = 32'hFC; rd_en1 = 1'b1;
    sb_push(1, "deb_st", 32'h1, 1'b1);
    step(1);
    rd_en1 = 1'b0;
    sb_push(1, "deb_clr", 32'h0, 1'b0);

    in1[32] = 1'b1;
    step(7);
    sb_push(1, "sim_f1", 32'h2, 1'b1);
    in1[0] = 1'b0;
    step(6);
    rd_en1 = 1'b1;
    sb_push(1, "sim_pre", 32'h2, 1'b1);
    step(1);
    rd_en1 = 1'b0;
    sb_push(1, "sim_post", 32'h1, 1'b1);
    step(1);
    addr1 = 32'hC0;
    sb_push(1, "sim_val", 32'h0, 1'b1);

    step(2);

    checks++;
    if (rd1 !== 32'h0 || irq1 !== 1'b1) begin
        errors++;
        $display("FAIL end_direct dut1: got data=%h irq=%b, expected data=00000000 irq=1", rd1, irq1);
    end else begin
        $display("ok   end_direct dut1: data=%h irq=%b", rd1, irq1);
    end

    if (errors != 0 || checks < 12) begin
        $display("FAIL summary: got %0d checks, %0d errors, expected >=12 checks and 0 errors", checks, errors);
    end else begin
        $display("PASS summary: %0d checks, %0d errors", checks, errors);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
